ps2_scan_controller: RTL and testbench

Sequences the byte stream from the PS/2 receiver into keyboard key events. It consumes each received byte (`rx_done_tick`/`dato`) and resolves the scan-code set 2 prefixes `E0` (extended) and `F0` (break). Completed events are queued in a small first-word-fall-through FIFO for the downstream consumer. It also tracks shift-key state and aborts stale partial sequences with a watchdog.

---
 rtl/ps2_scan_controller_if.sv | 39 +++
 rtl/ps2_scan_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_scan_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_controller_if.sv
// ---------------------------------------------------------------------------
// ps2_scan_controller_if
// Bundles the byte-input side and the event-output side of the PS/2 scan
// controller.
//   rx_done_tick : one-cycle strobe, dato holds a freshly received byte
//   dato         : received byte
//   rd_en        : consumer pops the head event
//   ev_valid     : event FIFO is non-empty
//   ev_code      : head event scan code
//   ev_ext       : head event carried the E0 prefix
//   ev_break     : head event is a key release
//   seq_err      : one-cycle pulse on protocol error or watchdog abort
//   overflow     : sticky, an event was dropped on a full FIFO
//   shift_held   : a shift key (left or right) is currently pressed
// The master modport is the producer/consumer side, the slave modport is
// the controller itself.
// ---------------------------------------------------------------------------
interface ps2_scan_controller_if;
  logic       rx_done_tick;
  logic [7:0] dato;
  logic       rd_en;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       seq_err;
  logic       overflow;
  logic       shift_held;

  modport master (
    output rx_done_tick, dato, rd_en,
    input  ev_valid, ev_code, ev_ext, ev_break, seq_err, overflow, shift_held
  );

  modport slave (
    input  rx_done_tick, dato, rd_en,
    output ev_valid, ev_code, ev_ext, ev_break, seq_err, overflow, shift_held
  );
endinterface

// File: rtl/ps2_scan_controller.sv
// ---------------------------------------------------------------------------
// ps2_scan_controller
// Turns the PS/2 scan-code set 2 byte stream into key events. E0 (extended)
// and F0 (break) prefixes are folded into each event, completed events are
// queued in a first-word-fall-through FIFO, shift-key state is tracked, and a
// watchdog abandons a prefix sequence that stalls.
// Ports:
//   clk_nexys : system clock
//   reset     : synchronous, active-low reset
//   bus       : ps2_scan_controller_if.slave (byte input, event output,
//               status flags)
// Parameters:
//   TIMEOUT_CYC : idle cycles before a partial prefix sequence is dropped
//   FIFO_DEPTH  : event FIFO entries, power of two, >= 2
// ---------------------------------------------------------------------------
module ps2_scan_controller #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_nexys,
  input  logic                   reset,
  ps2_scan_controller_if.slave   bus
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] BYTE_E0     = 8'hE0;
  localparam logic [7:0] BYTE_F0     = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRE_E0   = 2'd1,
    ST_PRE_F0   = 2'd2,
    ST_PRE_E0F0 = 2'd3
  } state_t;

  // Keyboard replies (BAT ok, ack, resend) and error/overrun codes carry no
  // key information and are dropped when no prefix is pending.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: is_discard = 1'b1;
      default:                           is_discard = 1'b0;
    endcase
  endfunction

  state_t            state_r;
  logic [WD_W-1:0]   wd_r;
  logic              push_req_r;
  logic [9:0]        push_data_r;
  logic              seq_err_r;
  logic              shift_l_r;
  logic              shift_r_r;
  logic              overflow_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [9:0]        mem_r [FIFO_DEPTH];

  state_t            dec_next_s;
  logic              dec_emit_s;
  logic              dec_ext_s;
  logic              dec_brk_s;
  logic              dec_err_s;
  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              wr_s;
  logic [9:0]        head_s;

  // Next-state decode of the byte on dato, as if a byte were present.
  always_comb begin
    dec_next_s = state_r;
    dec_emit_s = 1'b0;
    dec_ext_s  = 1'b0;
    dec_brk_s  = 1'b0;
    dec_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.dato == BYTE_E0) begin
          dec_next_s = ST_PRE_E0;
        end else if (bus.dato == BYTE_F0) begin
          dec_next_s = ST_PRE_F0;
        end else if (is_discard(bus.dato)) begin
          dec_next_s = ST_IDLE;
        end else begin
          dec_emit_s = 1'b1;
          dec_next_s = ST_IDLE;
        end
      end
      ST_PRE_E0: begin
        if (bus.dato == BYTE_F0) begin
          dec_next_s = ST_PRE_E0F0;
        end else if (bus.dato == BYTE_E0) begin
          // Repeated E0 keeps the extended prefix pending.
          dec_next_s = ST_PRE_E0;
        end else begin
          dec_emit_s = 1'b1;
          dec_ext_s  = 1'b1;
          dec_next_s = ST_IDLE;
        end
      end
      ST_PRE_F0: begin
        if ((bus.dato == BYTE_E0) || (bus.dato == BYTE_F0)) begin
          dec_err_s  = 1'b1;
          dec_next_s = ST_IDLE;
        end else begin
          dec_emit_s = 1'b1;
          dec_brk_s  = 1'b1;
          dec_next_s = ST_IDLE;
        end
      end
      ST_PRE_E0F0: begin
        if ((bus.dato == BYTE_E0) || (bus.dato == BYTE_F0)) begin
          dec_err_s  = 1'b1;
          dec_next_s = ST_IDLE;
        end else begin
          dec_emit_s = 1'b1;
          dec_ext_s  = 1'b1;
          dec_brk_s  = 1'b1;
          dec_next_s = ST_IDLE;
        end
      end
      default: begin
        dec_next_s = ST_IDLE;
      end
    endcase
  end

  // Decoder FSM, watchdog, shift tracking and the registered push request.
  always_ff @(posedge clk_nexys) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wd_r        <= '0;
      push_req_r  <= 1'b0;
      push_data_r <= 10'd0;
      seq_err_r   <= 1'b0;
      shift_l_r   <= 1'b0;
      shift_r_r   <= 1'b0;
    end else begin
      push_req_r <= 1'b0;
      seq_err_r  <= 1'b0;
      if (bus.rx_done_tick) begin
        // A byte always wins over a coincident timeout.
        wd_r        <= '0;
        state_r     <= dec_next_s;
        seq_err_r   <= dec_err_s;
        push_req_r  <= dec_emit_s;
        push_data_r <= {dec_ext_s, dec_brk_s, bus.dato};
        // Shift state follows decoded events even if the FIFO drops them.
        if (dec_emit_s && !dec_ext_s) begin
          if (bus.dato == CODE_LSHIFT) begin
            shift_l_r <= !dec_brk_s;
          end else if (bus.dato == CODE_RSHIFT) begin
            shift_r_r <= !dec_brk_s;
          end else begin
            shift_l_r <= shift_l_r;
          end
        end else begin
          shift_l_r <= shift_l_r;
        end
      end else if (state_r == ST_IDLE) begin
        wd_r <= '0;
      end else if (wd_r == WD_LAST) begin
        wd_r      <= '0;
        state_r   <= ST_IDLE;
        seq_err_r <= 1'b1;
      end else begin
        wd_r <= wd_r + WD_W'(1'b1);
      end
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = ((wr_ptr_r ^ rd_ptr_r) == {1'b1, {AW{1'b0}}});
  assign pop_s   = bus.rd_en && !empty_s;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign wr_s    = push_req_r && (!full_s || pop_s);
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk_nexys) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_req_r && !wr_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // FIFO storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk_nexys) begin
    if (wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_r;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  assign bus.ev_valid   = !empty_s;
  assign bus.ev_ext     = head_s[9];
  assign bus.ev_break   = head_s[8];
  assign bus.ev_code    = head_s[7:0];
  assign bus.seq_err    = seq_err_r;
  assign bus.overflow   = overflow_r;
  assign bus.shift_held = shift_l_r | shift_r_r;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_controller
// Directed bench for ps2_scan_controller: a table of single-byte vectors with
// hand-computed expected events, followed by hand-written sequences for FIFO
// overflow, push/pop collisions, watchdog timeout and reset mid-sequence.
// ---------------------------------------------------------------------------
module tb_ps2_scan_controller;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  ps2_scan_controller_if bus ();

  ps2_scan_controller #(
    .TIMEOUT_CYC (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_nexys (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_err;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_brk;
    logic       exp_shift;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [7:0] d, input logic err, input logic v,
                              input logic [7:0] c, input logic e, input logic b,
                              input logic s);
    vec_t r;
    r.data = d; r.exp_err = err; r.exp_valid = v; r.exp_code = c;
    r.exp_ext = e; r.exp_brk = b; r.exp_shift = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled by the following posedge.
  task automatic tick_byte(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.dato         = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.dato         = 8'h00;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] c, input logic e, input logic b);
    chk({name, "_valid"}, {15'd0, bus.ev_valid}, 16'd1);
    if (bus.ev_valid) begin
      chk({name, "_code"}, {8'd0, bus.ev_code}, {8'd0, c});
      chk({name, "_ext"},  {15'd0, bus.ev_ext}, {15'd0, e});
      chk({name, "_brk"},  {15'd0, bus.ev_break}, {15'd0, b});
    end
  endtask

  initial begin
    logic [7:0] exp_order [4];
    int first_err;
    int err_cycles;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(8'h59, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(8'h59, 1'b0, 1'b1, 8'h59, 1'b1, 1'b0, 1'b1);
    vecs[12] = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(8'h59, 1'b0, 1'b1, 8'h59, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(8'hFA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[24] = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[25] = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[26] = mk(8'h74, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0, 1'b0);
    vecs[27] = mk(8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[28] = mk(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[29] = mk(8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[30] = mk(8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    reset            = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.dato         = 8'h00;
    bus.rd_en        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state.
    chk("rst_valid",    {15'd0, bus.ev_valid},   16'd0);
    chk("rst_seq_err",  {15'd0, bus.seq_err},    16'd0);
    chk("rst_overflow", {15'd0, bus.overflow},   16'd0);
    chk("rst_shift",    {15'd0, bus.shift_held}, 16'd0);

    // Table: one byte per vector, an idle cycle, then check and drain.
    for (int i = 0; i < NV; i++) begin
      tick_byte(vecs[i].data);
      chk($sformatf("v%0d_err", i), {15'd0, bus.seq_err}, {15'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_valid_early", i), {15'd0, bus.ev_valid}, 16'd0);
      @(negedge clk);
      chk($sformatf("v%0d_err_clear", i), {15'd0, bus.seq_err}, 16'd0);
      chk($sformatf("v%0d_valid", i), {15'd0, bus.ev_valid}, {15'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid && bus.ev_valid) begin
        chk($sformatf("v%0d_code", i), {8'd0, bus.ev_code}, {8'd0, vecs[i].exp_code});
        chk($sformatf("v%0d_ext", i),  {15'd0, bus.ev_ext}, {15'd0, vecs[i].exp_ext});
        chk($sformatf("v%0d_brk", i),  {15'd0, bus.ev_break}, {15'd0, vecs[i].exp_brk});
      end
      chk($sformatf("v%0d_shift", i), {15'd0, bus.shift_held}, {15'd0, vecs[i].exp_shift});
      chk($sformatf("v%0d_ovf", i),   {15'd0, bus.overflow}, 16'd0);
      if (bus.ev_valid) begin
        pop_one();
        chk($sformatf("v%0d_drained", i), {15'd0, bus.ev_valid}, 16'd0);
      end
    end

    // rd_en on an empty FIFO, then push/pop collision while empty.
    pop_one();
    chk("empty_pop_valid", {15'd0, bus.ev_valid}, 16'd0);
    tick_byte(8'h1B);
    pop_one();
    chk_head("empty_collide", 8'h1B, 1'b0, 1'b0);
    pop_one();
    chk("empty_collide_drained", {15'd0, bus.ev_valid}, 16'd0);

    // Six makes with no reads: two are dropped.
    tick_byte(8'h15); tick_byte(8'h1D); tick_byte(8'h24);
    tick_byte(8'h2D); tick_byte(8'h2C); tick_byte(8'h35);
    @(negedge clk);
    chk("ovf_set", {15'd0, bus.overflow}, 16'd1);
    exp_order = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("ovf_pop%0d", k), exp_order[k], 1'b0, 1'b0);
      pop_one();
    end
    chk("ovf_empty", {15'd0, bus.ev_valid}, 16'd0);

    // Refill to full, then push 3C in the same cycle as a pop.
    tick_byte(8'h15); tick_byte(8'h1D); tick_byte(8'h24); tick_byte(8'h2D);
    tick_byte(8'h3C);
    pop_one();
    exp_order = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("full_pop%0d", k), exp_order[k], 1'b0, 1'b0);
      pop_one();
    end
    chk("full_empty", {15'd0, bus.ev_valid}, 16'd0);
    chk("ovf_sticky", {15'd0, bus.overflow}, 16'd1);

    // Reset with events queued discards them and clears overflow.
    tick_byte(8'h1C);
    @(negedge clk);
    do_reset();
    chk("rst2_valid",    {15'd0, bus.ev_valid}, 16'd0);
    chk("rst2_overflow", {15'd0, bus.overflow}, 16'd0);

    // Watchdog: E0 then silence; seq_err pulses 16 cycles after the byte.
    tick_byte(8'hE0);
    first_err  = 0;
    err_cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.seq_err) begin
        err_cycles++;
        if (first_err == 0) first_err = c;
      end
    end
    chk("wd_first",  16'(first_err),  16'd16);
    chk("wd_pulses", 16'(err_cycles), 16'd1);
    chk("wd_no_event", {15'd0, bus.ev_valid}, 16'd0);
    tick_byte(8'h1C);
    @(negedge clk);
    chk_head("wd_after", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // Reset mid-sequence drops the E0 prefix.
    tick_byte(8'hE0);
    do_reset();
    tick_byte(8'h74);
    @(negedge clk);
    chk_head("rst_mid", 8'h74, 1'b0, 1'b0);
    pop_one();

    // Keyboard replies in IDLE produce nothing.
    tick_byte(8'hAA);
    tick_byte(8'hFA);
    @(negedge clk);
    chk("reply_none", {15'd0, bus.ev_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
